// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Package     : alu_pkg
// Description : ALU control codes shared by the ALU, the ALU share arbiter
//               and the benches, plus the arbiter FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam logic [3:0] CONTROL_AND          = 4'b0000;
  localparam logic [3:0] CONTROL_OR           = 4'b0001;
  localparam logic [3:0] CONTROL_ADD          = 4'b0010;
  localparam logic [3:0] CONTROL_ADD_UNSIGNED = 4'b0011;
  localparam logic [3:0] CONTROL_SUB          = 4'b0110;
  localparam logic [3:0] CONTROL_SLT          = 4'b0111;
  localparam logic [3:0] CONTROL_NOR          = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/alu_share_arbiter_rr_grant.sv
`default_nettype none
// ============================================================================
// Module      : rr_grant
// Description : Combinational round-robin pick. Searches the valid vector
//               starting one past the last granted index (wrapping) and
//               returns a one-hot grant plus its binary index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_grant #(
  parameter int NUM_REQ = 2,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [IDW-1:0]     i_last,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDW-1:0]     o_idx
);

  // Walk from the farthest candidate to the nearest so the nearest valid one
  // after i_last overwrites earlier picks and ends up as the winner.
  always_comb begin
    int j;
    j       = 0;
    o_grant = '0;
    o_idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      j = (int'(i_last) + k) % NUM_REQ;
      if (i_valid[j]) begin
        o_grant    = '0;
        o_grant[j] = 1'b1;
        o_idx      = IDW'(j);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arbiter
// Description : Shares one clocked ALU among NUM_REQ requesters. Accepts one
//               operation at a time (round-robin), drives the ALU from
//               registers, waits ALU_LATENCY, and returns result + flags
//               tagged with the originating requester index.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int ALU_LATENCY = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*32-1:0]         req_input_a,
  input  logic [NUM_REQ*32-1:0]         req_input_b,
  input  logic [NUM_REQ*4-1:0]          req_control,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
  output logic [31:0]                   rsp_result,
  output logic                          rsp_zero,
  output logic                          rsp_overflow,
  output logic                          rsp_cout,
  output logic                          rsp_invalid,
  output logic [31:0]                   alu_input_a,
  output logic [31:0]                   alu_input_b,
  output logic [3:0]                    alu_control,
  input  logic [31:0]                   alu_result,
  input  logic                          alu_zero,
  input  logic                          alu_overflow,
  input  logic                          alu_cout,
  input  logic                          alu_invalid,
  output logic                          busy
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(ALU_LATENCY + 1);

  arb_state_e           r_state;
  logic [IDW-1:0]       r_last;
  logic [CW-1:0]        r_cnt;

  logic [NUM_REQ-1:0]   w_grant;
  logic [IDW-1:0]       w_idx;
  logic                 w_accept;
  logic [31:0]          w_a;
  logic [31:0]          w_b;
  logic [3:0]           w_ctl;

  rr_grant #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_rr_grant (
    .i_valid (req_valid),
    .i_last  (r_last),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

  // Ready is offered only in IDLE and never while reset is held, since the
  // async reset parks the FSM in IDLE.
  assign req_ready = (r_state == ST_IDLE && !reset) ? w_grant : '0;
  assign w_accept  = |(req_valid & req_ready);
  assign busy      = (r_state != ST_IDLE);

  assign w_a   = req_input_a[int'(w_idx)*32 +: 32];
  assign w_b   = req_input_b[int'(w_idx)*32 +: 32];
  assign w_ctl = req_control[int'(w_idx)*4 +: 4];

  // Sequencer: accept -> wait ALU latency -> hold response until consumed.
  // The counter is loaded with ALU_LATENCY and the capture happens on the
  // edge after it reaches zero, giving capture at accept + ALU_LATENCY + 1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_last       <= IDW'(NUM_REQ - 1);
      r_cnt        <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_cout     <= 1'b0;
      rsp_invalid  <= 1'b0;
      alu_input_a  <= '0;
      alu_input_b  <= '0;
      alu_control  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            alu_input_a <= w_a;
            alu_input_b <= w_b;
            alu_control <= w_ctl;
            rsp_id      <= w_idx;
            r_last      <= w_idx;
            r_cnt       <= CW'(ALU_LATENCY);
            r_state     <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (r_cnt == '0) begin
            rsp_result   <= alu_result;
            rsp_zero     <= alu_zero;
            rsp_overflow <= alu_overflow;
            rsp_cout     <= alu_cout;
            rsp_invalid  <= alu_invalid;
            rsp_valid    <= 1'b1;
            r_state      <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_share_arbiter
// Description : Scoreboard bench for alu_share_arbiter. A behavioural ALU
//               stub answers the DUT's ALU ports; a round-robin reference
//               predicts grants and pushes expected responses into a queue
//               that a negedge monitor pops on each response handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int N = 2;
  localparam int L = 1;

  typedef struct packed {
    logic [31:0] r;
    logic        z;
    logic        ov;
    logic        co;
    logic        inv;
  } alu_out_t;

  typedef struct {
    int       id;
    alu_out_t o;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // ---------------- main DUT (2 requesters, latency 1) ----------------
  logic [N-1:0]    req_valid, req_ready;
  logic [N*32-1:0] req_input_a, req_input_b;
  logic [N*4-1:0]  req_control;
  logic            rsp_valid, rsp_ready;
  logic [0:0]      rsp_id;
  logic [31:0]     rsp_result;
  logic            rsp_zero, rsp_overflow, rsp_cout, rsp_invalid;
  logic [31:0]     alu_input_a, alu_input_b;
  logic [3:0]      alu_control;
  logic [31:0]     alu_result;
  logic            alu_zero, alu_overflow, alu_cout, alu_invalid;
  logic            busy;

  alu_share_arbiter #(.NUM_REQ(N), .ALU_LATENCY(L)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_input_a(req_input_a), .req_input_b(req_input_b), .req_control(req_control),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow),
    .rsp_cout(rsp_cout), .rsp_invalid(rsp_invalid),
    .alu_input_a(alu_input_a), .alu_input_b(alu_input_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .alu_cout(alu_cout), .alu_invalid(alu_invalid),
    .busy(busy)
  );

  // ---------------- second DUT (3 requesters, latency 3) ----------------
  logic [2:0]   req_valid3, req_ready3;
  logic [95:0]  req_input_a3, req_input_b3;
  logic [11:0]  req_control3;
  logic         rsp_valid3, rsp_ready3;
  logic [1:0]   rsp_id3;
  logic [31:0]  rsp_result3;
  logic         rsp_zero3, rsp_overflow3, rsp_cout3, rsp_invalid3;
  logic [31:0]  alu_input_a3, alu_input_b3;
  logic [3:0]   alu_control3;
  logic [31:0]  alu_result3;
  logic         alu_zero3, alu_overflow3, alu_cout3, alu_invalid3;
  logic         busy3;

  alu_share_arbiter #(.NUM_REQ(3), .ALU_LATENCY(3)) dut3 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid3), .req_ready(req_ready3),
    .req_input_a(req_input_a3), .req_input_b(req_input_b3), .req_control(req_control3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_id(rsp_id3),
    .rsp_result(rsp_result3), .rsp_zero(rsp_zero3), .rsp_overflow(rsp_overflow3),
    .rsp_cout(rsp_cout3), .rsp_invalid(rsp_invalid3),
    .alu_input_a(alu_input_a3), .alu_input_b(alu_input_b3), .alu_control(alu_control3),
    .alu_result(alu_result3), .alu_zero(alu_zero3), .alu_overflow(alu_overflow3),
    .alu_cout(alu_cout3), .alu_invalid(alu_invalid3),
    .busy(busy3)
  );

  // ---------------- behavioural ALU ----------------
  function automatic alu_out_t alu_ref(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    alu_out_t    o;
    o = '0;
    s = '0;
    case (c)
      CONTROL_AND: o.r = a & b;
      CONTROL_OR:  o.r = a | b;
      CONTROL_NOR: o.r = ~(a | b);
      CONTROL_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        o.r = s[31:0]; o.co = s[32];
        o.ov = (a[31] == b[31]) && (o.r[31] != a[31]);
      end
      CONTROL_ADD_UNSIGNED: begin
        s = {1'b0, a} + {1'b0, b};
        o.r = s[31:0]; o.co = s[32];
      end
      CONTROL_SUB: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        o.r = s[31:0]; o.co = s[32];
        o.ov = (a[31] != b[31]) && (o.r[31] != a[31]);
      end
      CONTROL_SLT: o.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default:     o.inv = 1'b1;
    endcase
    o.z = (o.r == 32'd0);
    return o;
  endfunction

  alu_out_t p1;
  alu_out_t p3 [3];
  always @(posedge clock) begin
    p1    <= alu_ref(alu_control, alu_input_a, alu_input_b);
    p3[0] <= alu_ref(alu_control3, alu_input_a3, alu_input_b3);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign {alu_result, alu_zero, alu_overflow, alu_cout, alu_invalid}      = p1;
  assign {alu_result3, alu_zero3, alu_overflow3, alu_cout3, alu_invalid3} = p3[2];

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] rr_pick(input logic [N-1:0] v, input int last);
    logic [N-1:0] g;
    g = '0;
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N] && g == '0) g[(last + k) % N] = 1'b1;
    end
    return g;
  endfunction

  // ---------------- reference + scoreboard monitor ----------------
  exp_t         q[$];
  int           grant_log[$];
  int           m_last = N - 1;
  bit           outstanding = 0;
  int           acc_cyc = 0;
  logic [N-1:0] last_acc = '0;
  bit           prev_rv = 0, prev_rr = 0;
  logic [36:0]  held;

  always @(negedge clock) begin
    logic [N-1:0] exp_ready;
    exp_t         e;
    if (reset) begin
      q.delete();
      outstanding = 0;
      m_last      = N - 1;
      prev_rv     = 0;
      prev_rr     = 0;
      last_acc    = '0;
    end else begin
      exp_ready = outstanding ? '0 : rr_pick(req_valid, m_last);
      chk("req_ready", 64'(req_ready), 64'(exp_ready));
      last_acc = '0;
      if (exp_ready != '0) begin
        for (int i = 0; i < N; i++) begin
          if (exp_ready[i]) begin
            e.id = i;
            e.o  = alu_ref(req_control[i*4 +: 4], req_input_a[i*32 +: 32], req_input_b[i*32 +: 32]);
            q.push_back(e);
            grant_log.push_back(i);
            m_last      = i;
            last_acc[i] = 1'b1;
          end
        end
        outstanding = 1;
        acc_cyc     = cyc + 1;
      end
      if (rsp_valid && !prev_rv) chk("rsp_latency", 64'(cyc - acc_cyc), 64'(L + 1));
      if (rsp_valid && prev_rv && !prev_rr)
        chk("rsp_hold_stable", 64'({rsp_id, rsp_result, rsp_zero, rsp_overflow, rsp_cout, rsp_invalid}), 64'(held));
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) begin
          chk("rsp_unexpected", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          chk("rsp_id", 64'(rsp_id), 64'(e.id));
          chk("rsp_data", 64'({rsp_result, rsp_zero, rsp_overflow, rsp_cout, rsp_invalid}), 64'(e.o));
        end
        outstanding = 0;
      end
      held    = {rsp_id, rsp_result, rsp_zero, rsp_overflow, rsp_cout, rsp_invalid};
      prev_rv = rsp_valid;
      prev_rr = rsp_ready;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input int i, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    req_input_a[i*32 +: 32] = a;
    req_input_b[i*32 +: 32] = b;
    req_control[i*4 +: 4]   = c;
    req_valid[i]            = 1'b1;
  endtask

  task automatic wait_acc(input int i, input int budget);
    int k = 0;
    do begin @(posedge clock); #1; k++; end while (!last_acc[i] && k < budget);
    chk("accept_timeout", 64'(last_acc[i]), 64'd1);
  endtask

  task automatic wait_rsp(input int budget);
    int k = 0;
    do begin @(negedge clock); #1; k++; end while (!rsp_valid && k < budget);
    chk("rsp_timeout", 64'(rsp_valid), 64'd1);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    do begin @(posedge clock); #1; k++; end while ((outstanding || q.size() != 0) && k < budget);
    chk("drain_timeout", 64'(outstanding || q.size() != 0), 64'd0);
  endtask

  task automatic do_reset();
    @(posedge clock); #1 reset = 1'b1;
    @(negedge clock); #1;
    @(posedge clock); #1 reset = 1'b0;
  endtask

  function automatic logic [31:0] rand_opnd();
    logic [31:0] corners [5];
    corners = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  task automatic drive_random();
    logic [3:0] ops [8];
    ops = '{CONTROL_AND, CONTROL_OR, CONTROL_NOR, CONTROL_ADD,
            CONTROL_ADD_UNSIGNED, CONTROL_SUB, CONTROL_SLT, 4'hF};
    for (int i = 0; i < N; i++) begin
      if (last_acc[i] || !req_valid[i]) begin
        if ($urandom_range(0, 3) != 0) set_req(i, ops[$urandom_range(0, 7)], rand_opnd(), rand_opnd());
        else req_valid[i] = 1'b0;
      end else if ($urandom_range(0, 15) == 0) begin
        req_valid[i] = 1'b0;
      end
    end
    rsp_ready = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int p;
    int acc3;
    int k;
    reset = 1'b1;
    req_valid = '0; req_input_a = '0; req_input_b = '0; req_control = '0;
    rsp_ready = 1'b0;
    req_valid3 = '0; req_input_a3 = '0; req_input_b3 = '0; req_control3 = '0;
    rsp_ready3 = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    set_req(0, CONTROL_ADD, 32'd3, 32'd1);
    #1;
    chk("reset_req_ready", 64'(req_ready), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp", 64'({rsp_id, rsp_result, rsp_zero, rsp_overflow, rsp_cout, rsp_invalid}), 64'd0);
    chk("reset_alu", 64'({alu_input_a, alu_input_b, alu_control}), 64'd0);
    @(posedge clock); #1 reset = 1'b0;

    // single request
    rsp_ready = 1'b1;
    wait_acc(0, 5);
    req_valid[0] = 1'b0;
    wait_rsp(10);
    chk("single_result", 64'(rsp_result), 64'd4);
    chk("single_id", 64'(rsp_id), 64'd0);
    chk("single_flags", 64'({rsp_zero, rsp_overflow, rsp_cout, rsp_invalid}), 64'd0);
    wait_idle(10);

    // fairness
    do_reset();
    grant_log.delete();
    set_req(0, CONTROL_SUB, 32'd1, 32'd1);
    set_req(1, CONTROL_OR, 32'd2, 32'd1);
    k = 0;
    while (grant_log.size() < 4 && k < 60) begin @(posedge clock); #1; k++; end
    req_valid = '0;
    chk("fair_count", 64'(grant_log.size() >= 4), 64'd1);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) chk("fair_order", 64'(grant_log[i]), 64'(i % 2));
    wait_idle(20);

    // backpressure
    rsp_ready = 1'b0;
    set_req(0, CONTROL_ADD, 32'h7FFFFFFF, 32'd1);
    wait_acc(0, 5);
    req_valid[0] = 1'b0;
    set_req(1, CONTROL_AND, 32'h0000F0F0, 32'h0000FF00);
    wait_rsp(10);
    for (int i = 0; i < 5; i++) begin
      chk("bp_result", 64'(rsp_result), 64'h80000000);
      chk("bp_overflow", 64'(rsp_overflow), 64'd1);
      chk("bp_ready_low", 64'(req_ready), 64'd0);
      @(negedge clock); #1;
    end
    @(posedge clock); #1;
    p = cyc;
    rsp_ready = 1'b1;
    wait_acc(1, 10);
    chk("bp_reissue_gap", 64'(cyc - p), 64'd2);
    req_valid[1] = 1'b0;
    wait_idle(20);

    // invalid control then SLT
    set_req(1, 4'hF, 32'h12345678, 32'h9ABCDEF0);
    wait_acc(1, 5);
    req_valid[1] = 1'b0;
    wait_rsp(10);
    chk("inv_flag", 64'(rsp_invalid), 64'd1);
    chk("inv_id", 64'(rsp_id), 64'd1);
    wait_idle(10);
    set_req(0, CONTROL_SLT, 32'hFFFFFFFF, 32'd0);
    wait_acc(0, 5);
    req_valid[0] = 1'b0;
    wait_rsp(10);
    chk("slt_result", 64'(rsp_result), 64'd1);
    chk("slt_invalid", 64'(rsp_invalid), 64'd0);
    wait_idle(10);

    // reset while in EXEC
    set_req(1, CONTROL_ADD, 32'd10, 32'd20);
    wait_acc(1, 5);
    req_valid[1] = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("rst_mid_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_alu", 64'({alu_input_a, alu_input_b, alu_control}), 64'd0);
    @(negedge clock); #1;
    @(posedge clock); #1 reset = 1'b0;
    grant_log.delete();
    set_req(0, CONTROL_NOR, 32'h0, 32'h0);
    set_req(1, CONTROL_AND, 32'hFFFF0000, 32'h00FFFF00);
    k = 0;
    while (grant_log.size() < 1 && k < 10) begin @(posedge clock); #1; k++; end
    req_valid = '0;
    chk("rst_first_grant", 64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'd0);
    wait_idle(20);

    // randomized traffic
    repeat (4000) begin
      @(posedge clock); #1;
      drive_random();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle(60);

    // latency sweep on the 3-requester, latency-3 instance
    @(posedge clock); #1;
    req_input_a3[64 +: 32] = 32'd5;
    req_input_b3[64 +: 32] = 32'd6;
    req_control3[8 +: 4]   = CONTROL_ADD;
    req_valid3             = 3'b100;
    rsp_ready3             = 1'b1;
    acc3 = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (req_ready3[2]) begin acc3 = cyc + 1; break; end
    end
    chk("lat3_grant", 64'(acc3 >= 0), 64'd1);
    @(posedge clock); #1 req_valid3 = '0;
    k = 0;
    do begin @(negedge clock); k++; end while (!rsp_valid3 && k < 20);
    chk("lat3_latency", 64'(cyc - acc3), 64'd4);
    chk("lat3_result", 64'(rsp_result3), 64'd11);
    chk("lat3_id", 64'(rsp_id3), 64'd2);
    @(posedge clock); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
